imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Loader-side signal bundle: start control, byte-stream handshake,
// instruction-memory write port and load status.
interface imem_loader_if #(
   parameter int ADDR_W = 12
);
   logic              start;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic [ADDR_W-1:0] address_imem;
   logic [31:0]       data_imem;
   logic              wren_imem;
   logic              cpu_reset;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   modport slave (
      input  start, rx_valid, rx_data,
      output rx_ready, address_imem, data_imem, wren_imem,
             cpu_reset, done, err, words_loaded
   );

   modport master (
      output start, rx_valid, rx_data,
      input  rx_ready, address_imem, data_imem, wren_imem,
             cpu_reset, done, err, words_loaded
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed big-endian byte stream into 32-bit
// words and writes them to instruction memory, holding the CPU in reset.
module imem_loader #(
   parameter int ADDR_W = 12
) (
   input logic          clock,
   input logic          reset,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR
   } state_e;

   localparam logic [31:0]   MAX_WORDS = 32'd1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [15:0]       n_q, n_d;
   logic [23:0]       part_q, part_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       dout_q, dout_d;
   logic              rdy;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         n_q     <= '0;
         part_q  <= '0;
         bidx_q  <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         part_q  <= part_d;
         bidx_q  <= bidx_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
      end
   end

   // cnt_q is both the word index and words_loaded; it is one bit wider
   // than the address so a full-memory load never wraps.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      part_d  = part_q;
      bidx_d  = bidx_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      rdy     = 1'b0;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (bus.start) begin
               state_d = HDR_HI;
               cnt_d   = '0;
               bidx_d  = '0;
            end
         end
         HDR_HI: begin
            rdy = 1'b1;
            if (bus.rx_valid) begin
               n_d     = {bus.rx_data, n_q[7:0]};
               state_d = HDR_LO;
            end
         end
         HDR_LO: begin
            rdy = 1'b1;
            if (bus.rx_valid) begin
               n_d = {n_q[15:8], bus.rx_data};
               if (n_d == 16'd0 || {16'd0, n_d} > MAX_WORDS)
                  state_d = ERR;
               else
                  state_d = DATA;
            end
         end
         DATA: begin
            rdy = 1'b1;
            if (bus.rx_valid) begin
               part_d = {part_q[15:0], bus.rx_data};
               bidx_d = bidx_q + 2'd1;
               // Latch the write port now so wren rises the cycle after byte 4.
               if (bidx_q == 2'd3) begin
                  state_d = WRITE;
                  addr_d  = cnt_q[ADDR_W-1:0];
                  dout_d  = {part_q, bus.rx_data};
               end
            end
         end
         WRITE: begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = (32'(cnt_d) == {16'd0, n_q}) ? DONE : DATA;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rx_ready     = rdy;
   assign bus.wren_imem    = (state_q == WRITE);
   assign bus.address_imem = addr_q;
   assign bus.data_imem    = dout_q;
   assign bus.cpu_reset    = (state_q != DONE);
   assign bus.done         = (state_q == DONE);
   assign bus.err          = (state_q == ERR);
   assign bus.words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, randomized loads against
// a queue-based stream model, and hand sequences for reset/latency corners.
module tb_imem_loader;
   localparam int AW   = 12;
   localparam int MAXW = 1 << AW;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   imem_loader_if #(.ADDR_W(AW)) ifc();
   imem_loader #(.ADDR_W(AW)) dut (.clock(clock), .reset(reset), .bus(ifc));

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] exp_q[$];

   typedef struct {
      logic [15:0] n;
      int          gap;
      bit          poke;
      bit          exp_err;
      int          exp_words;
   } vec_t;
   vec_t tbl[7];

   // Write log: one entry per cycle with the write enable high.
   always @(negedge clock)
      if (!reset && ifc.wren_imem) begin
         wr_addr_q.push_back(32'(ifc.address_imem));
         wr_data_q.push_back(ifc.data_imem);
      end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k;
      k = 0;
      ifc.rx_valid = 1'b1;
      ifc.rx_data  = b;
      while (!ifc.rx_ready && k < 20) begin
         step();
         k++;
      end
      if (k == 20) chk("rx_ready_wait", ifc.rx_ready, 1);
      step();
      ifc.rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
   endtask

   function automatic int model_words(input int n);
      return (n >= 1 && n <= MAXW) ? n : 0;
   endfunction

   task automatic do_load(input logic [15:0] n, input int gap, input bit poke,
                          input bit exp_err, input int exp_words);
      logic [31:0] w;
      int k;
      ifc.rx_valid = 1'b1;
      ifc.rx_data  = 8'($urandom);
      step();
      step();
      ifc.rx_valid = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
      exp_q.delete();
      pulse_start();
      chk("start_rx_ready", ifc.rx_ready, 1);
      chk("start_cpu_reset", ifc.cpu_reset, 1);
      chk("start_done", ifc.done, 0);
      chk("start_err", ifc.err, 0);
      chk("start_words", ifc.words_loaded, 0);
      send_byte(n[15:8]);
      send_byte(n[7:0]);
      for (int i = 0; i < model_words(int'(n)); i++) begin
         w = $urandom;
         exp_q.push_back(w);
         for (int b = 3; b >= 0; b--) begin
            send_byte(w[8*b +: 8]);
            if (poke && i == 0 && b == 2) pulse_start();
            if (gap == 1) step();
            else if (gap == 2) repeat ($urandom_range(0, 2)) step();
         end
      end
      k = 0;
      while (!ifc.done && !ifc.err && k < 10) begin
         step();
         k++;
      end
      step();
      chk("err", ifc.err, exp_err);
      chk("done", ifc.done, !exp_err);
      chk("cpu_reset", ifc.cpu_reset, exp_err);
      chk("words_loaded", ifc.words_loaded, exp_words);
      chk("rx_ready_after", ifc.rx_ready, 0);
      chk("n_writes", wr_addr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
         chk("wr_addr", wr_addr_q[i], i);
         chk("wr_data", wr_data_q[i], exp_q[i]);
      end
   endtask

   initial begin
      logic [15:0] rn;
      logic [7:0]  bytes1[6];
      tbl[0] = '{16'd1,      0, 1'b0, 1'b0, 1};
      tbl[1] = '{16'd0,      0, 1'b0, 1'b1, 0};
      tbl[2] = '{16'h1001,   0, 1'b0, 1'b1, 0};
      tbl[3] = '{16'hFFFF,   0, 1'b0, 1'b1, 0};
      tbl[4] = '{16'd3,      1, 1'b0, 1'b0, 3};
      tbl[5] = '{16'd4,      2, 1'b0, 1'b0, 4};
      tbl[6] = '{16'd2,      0, 1'b1, 1'b0, 2};

      ifc.start = 1'b0;
      ifc.rx_valid = 1'b0;
      ifc.rx_data = 8'h00;
      reset = 1'b1;
      step();
      step();
      chk("rst_rx_ready", ifc.rx_ready, 0);
      chk("rst_wren", ifc.wren_imem, 0);
      chk("rst_addr", ifc.address_imem, 0);
      chk("rst_data", ifc.data_imem, 0);
      chk("rst_cpu_reset", ifc.cpu_reset, 1);
      chk("rst_done", ifc.done, 0);
      chk("rst_err", ifc.err, 0);
      chk("rst_words", ifc.words_loaded, 0);
      reset = 1'b0;
      repeat (3) step();
      chk("idle_hold_ready", ifc.rx_ready, 0);
      chk("idle_hold_cpu_reset", ifc.cpu_reset, 1);

      // Single word, back-to-back: write must appear right after byte 4.
      wr_addr_q.delete();
      wr_data_q.delete();
      bytes1 = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(bytes1[i]);
      chk("sw_wren", ifc.wren_imem, 1);
      chk("sw_addr", ifc.address_imem, 0);
      chk("sw_data", ifc.data_imem, 32'h12345678);
      chk("sw_rx_ready_write", ifc.rx_ready, 0);
      step();
      chk("sw_wren_low", ifc.wren_imem, 0);
      chk("sw_done", ifc.done, 1);
      chk("sw_cpu_reset", ifc.cpu_reset, 0);
      chk("sw_words", ifc.words_loaded, 1);
      chk("sw_data_hold", ifc.data_imem, 32'h12345678);
      chk("sw_n_writes", wr_addr_q.size(), 1);

      // Async reset in the middle of the second word.
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      send_byte(8'h11); send_byte(8'h22);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_rx_ready", ifc.rx_ready, 0);
      chk("mid_rst_wren", ifc.wren_imem, 0);
      chk("mid_rst_addr", ifc.address_imem, 0);
      chk("mid_rst_data", ifc.data_imem, 0);
      chk("mid_rst_cpu_reset", ifc.cpu_reset, 1);
      chk("mid_rst_done", ifc.done, 0);
      chk("mid_rst_err", ifc.err, 0);
      chk("mid_rst_words", ifc.words_loaded, 0);
      step();
      reset = 1'b0;
      step();
      chk("post_rst_idle", ifc.rx_ready, 0);
      do_load(16'd3, 0, 1'b0, 1'b0, 3);

      for (int t = 0; t < 7; t++)
         do_load(tbl[t].n, tbl[t].gap, tbl[t].poke, tbl[t].exp_err, tbl[t].exp_words);

      for (int r = 0; r < 8; r++) begin
         rn = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
         do_load(rn, 2, (rn != 0) && ($urandom_range(0, 1) == 1),
                 model_words(int'(rn)) == 0, model_words(int'(rn)));
      end

      do_load(16'h1000, 0, 1'b0, 1'b0, MAXW);
      if (wr_addr_q.size() > 0) chk("full_last_addr", wr_addr_q[$], MAXW - 1);
      else chk("full_write_count", wr_addr_q.size(), MAXW);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
